// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU package for the writeback path.
// Holds register-file geometry, the writeback priority state encoding and a
// small helper used by the arbiter to pick the next priority state.
package regfile_wb_arbiter_pkg;

  localparam int REG_AW   = 5;   // register address width
  localparam int DATA_W   = 32;  // register data width
  localparam int NUM_REGS = 32;  // architectural register count

  // Round-robin priority: PRI0 favours requester 0, PRI1 favours requester 1.
  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_state_e;

  // After a grant the other requester becomes favoured.
  function automatic pri_state_e pri_after_grant(input logic granted_r1);
    return granted_r1 ? PRI0 : PRI1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus shared by the two writeback requesters.
// Requester 0 is the ALU, requester 1 the load / multi-cycle unit.
//   rN_valid : requester N has a write pending
//   rN_addr  : destination register
//   rN_data  : write data
//   rN_ready : write accepted this cycle (valid & ready = transfer)
// master modport: the requesters side; slave modport: the arbiter side.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic              r0_valid;
  logic [REG_AW-1:0] r0_addr;
  logic [DATA_W-1:0] r0_data;
  logic              r0_ready;

  logic              r1_valid;
  logic [REG_AW-1:0] r1_addr;
  logic [DATA_W-1:0] r1_data;
  logic              r1_ready;

  modport master (
    output r0_valid, r0_addr, r0_data,
    output r1_valid, r1_addr, r1_data,
    input  r0_ready, r1_ready
  );

  modport slave (
    input  r0_valid, r0_addr, r0_data,
    input  r1_valid, r1_addr, r1_data,
    output r0_ready, r1_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Register scoreboard for the writeback path.
// Tracks which registers have a write outstanding and answers the decode
// stage's hazard query.
//   clk, rst          : clock, asynchronous active-low reset
//   alloc_en/addr     : issue marks a destination pending (register 0 ignored)
//   clr_en/clr_addr   : register-file write that retires a pending destination
//   q_a1, q_a2        : decode source registers
//   q_stall           : a queried source is pending
//   busy[31:0]        : bit k set = register k has a write outstanding
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [REG_AW-1:0]   alloc_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  input  logic [REG_AW-1:0]   q_a1,
  input  logic [REG_AW-1:0]   q_a2,
  output logic                q_stall,
  output logic [NUM_REGS-1:0] busy
);

  // Register 0 is hardwired zero, so it can never be pending.
  assign busy[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      logic busy_reg;

      assign set_hit = alloc_en && (alloc_addr == REG_AW'(gi));
      assign clr_hit = clr_en && (clr_addr == REG_AW'(gi));

      // Set is tested first: a same-cycle allocation means a newer producer
      // is pending, so the retiring write must not clear it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_reg <= 1'b0;
        end else if (set_hit) begin
          busy_reg <= 1'b1;
        end else if (clr_hit) begin
          busy_reg <= 1'b0;
        end
      end

      assign busy[gi] = busy_reg;
    end
  endgenerate

  assign q_stall = rst && (busy[q_a1] || busy[q_a2]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file.
// Two requesters share the single register-file write port. A 1-bit
// round-robin priority resolves conflicts, a lone requester is always
// granted, and accepted writes reach the write port one cycle later.
//   clk, rst             : clock, asynchronous active-low reset
//   req (slave)          : requester bus (r0_*/r1_* valid/addr/data/ready)
//   alloc_en, alloc_addr : issue marks a destination pending
//   q_a1, q_a2, q_stall  : decode hazard query and stall
//   we3, a3, wd3         : register-file write port (a3/wd3 hold when idle)
//   busy[31:0]           : scoreboard contents
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave req,
  input  logic                alloc_en,
  input  logic [REG_AW-1:0]   alloc_addr,
  input  logic [REG_AW-1:0]   q_a1,
  input  logic [REG_AW-1:0]   q_a2,
  output logic                q_stall,
  output logic                we3,
  output logic [REG_AW-1:0]   a3,
  output logic [DATA_W-1:0]   wd3,
  output logic [NUM_REGS-1:0] busy
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   grant;
  pri_state_e        state_reg;
  pri_state_e        state_next;
  logic [REG_AW-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              write_ok;

  assign req_valid = {req.r1_valid, req.r0_valid};

  // Priority state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= PRI0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next priority: flip away from whoever was granted, hold when idle.
  always_comb begin
    state_next = state_reg;
    if (grant[0]) begin
      state_next = pri_after_grant(1'b0);
    end else if (grant[1]) begin
      state_next = pri_after_grant(1'b1);
    end
  end

  // Grants. The priority state only matters when both requesters are valid,
  // so a lone requester never sees a bubble. Nothing is granted in reset.
  always_comb begin
    grant = '0;
    if (rst) begin
      if (req_valid[0] && (!req_valid[1] || state_reg == PRI0)) begin
        grant[0] = 1'b1;
      end
      if (req_valid[1] && (!req_valid[0] || state_reg == PRI1)) begin
        grant[1] = 1'b1;
      end
    end
  end

  assign req.r0_ready = grant[0];
  assign req.r1_ready = grant[1];

  assign sel_addr = grant[1] ? req.r1_addr : req.r0_addr;
  assign sel_data = grant[1] ? req.r1_data : req.r0_data;

  // Writes to register 0 are acknowledged but never reach the write port.
  assign write_ok = (|grant) && (sel_addr != '0);

  // Output stage: a3/wd3 only load on a real write so they hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else begin
      we3 <= write_ok;
      if (write_ok) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_en     (we3),
    .clr_addr   (a3),
    .q_a1       (q_a1),
    .q_a2       (q_a2),
    .q_stall    (q_stall),
    .busy       (busy)
  );

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of writeback requesters; only 2 is supported.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 (ALU writeback) has a write pending.
- r0_addr  in  5  requester 0 destination register.
- r0_data  in  32  requester 0 write data.
- r0_ready  out  1  requester 0 write accepted this cycle.
- r1_valid, r1_addr, r1_data, r1_ready  same widths and meanings for requester 1 (load/multi-cycle unit).
- alloc_en  in  1  issue stage marks a destination as pending.
- alloc_addr  in  5  register being marked pending.
- q_a1, q_a2  in  5  source registers of the instruction in decode.
- q_stall  out  1  decode must stall; a queried source is pending.
- we3  out  1  register-file write enable.
- a3  out  5  register-file write address.
- wd3  out  32  register-file write data.
- busy  out  32  scoreboard; bit k set = register k has a write outstanding.

Function
REQ-003 The block SHALL grant at most one requester per cycle; a request is accepted when rX_valid and rX_ready are both 1.
REQ-004 rX_ready SHALL be combinational from the valid inputs and the priority state, and SHALL be 1 only when rX_valid is 1.
REQ-005 Arbitration SHALL be round-robin with a 1-bit priority FSM, states PRI0 and PRI1.
REQ-006 In PRI0, r0 SHALL win a conflict; in PRI1, r1 SHALL win a conflict.
REQ-007 After a grant to rN, the FSM SHALL move to the state favouring the other requester; with no grant it SHALL hold.
REQ-008 A lone valid requester SHALL be granted regardless of FSM state, so there are no bubbles.
REQ-009 An accepted write SHALL be registered into an output stage and appear on we3/a3/wd3 in the next cycle, giving a fixed latency of 1.
REQ-010 The output stage SHALL accept every cycle; we3 SHALL be 0 in any cycle following a cycle with no acceptance.
REQ-011 An accepted write to address 0 SHALL be acknowledged via ready and dropped: we3=0 and the busy vector is unchanged.
REQ-012 busy[k] SHALL be set the cycle after alloc_en=1 with alloc_addr=k, for k!=0; alloc of register 0 SHALL be ignored, so busy[0] is always 0.
REQ-013 busy[k] SHALL be cleared the cycle after we3=1 with a3=k.
REQ-014 If a set and a clear of the same k occur in the same cycle, set SHALL win, because a newer producer is pending.
REQ-015 q_stall SHALL be combinational: q_stall = busy[q_a1] OR busy[q_a2]; register 0 never stalls.
REQ-016 The scoreboard SHALL not count multiple outstanding writes to one register; issue logic guarantees at most one per register.
REQ-017 wd3 and a3 SHALL hold their last values when we3=0; only we3 is qualifying.

Reset
REQ-018 While rst=0, the block SHALL asynchronously force: FSM to PRI0, we3=0, a3=0, wd3=0, busy=0.
REQ-019 While rst=0, r0_ready, r1_ready and q_stall SHALL be 0.
REQ-020 Reset mid-operation SHALL discard any registered in-flight write, which is never written.
REQ-021 The first edge after rst deasserts SHALL behave as a normal cycle in PRI0.

Structure
REQ-022 Register address width (5), data width (32), register count (32), and the FSM state encoding (PRI0=0, PRI1=1) SHALL live in the shared CPU package.
REQ-023 The block SHALL contain one natural sub-module, wb_scoreboard, holding busy[31:0] and the set/clear/query logic; the arbiter FSM and output stage stay in the top.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Only r0_valid, addr=5, data=0xDEADBEEF -> r0_ready=1 that cycle; next cycle we3=1, a3=5, wd3=0xDEADBEEF.
- Both valid for 4 cycles from reset (r0 addr=1, r1 addr=2) -> grants r0, r1, r0, r1; a3 sequence 1, 2, 1, 2 lagging one cycle.
- alloc_en addr=7, then q_a1=7 -> q_stall=1 until the cycle after r1 writes addr 7, then q_stall=0.
- alloc addr=9 in the same cycle that we3=1 with a3=9 -> busy[9] remains 1.
- r0 writes addr=0, data=0x1234 -> r0_ready=1, we3 stays 0; alloc addr=0 leaves busy=0; q_a1=0 gives q_stall=0.
- Assert rst=0 between a grant and its write cycle -> we3 is 0 immediately, busy=0, and the FSM is PRI0 after release; a conflict then grants r0.
